safe_wrapper_job_launcher: RTL and testbench

Hardware register-bus initiator that drives the safe wrapper control register file from the far end of its register interface. It accepts a job descriptor (master core, DMR mask, safe configuration), programs the control registers, and writes `start`. It then waits for the end-of-routine interrupt, samples the hart status, acknowledges the interrupt, and returns a completion record. It sits between a host-side job queue or DMA and the safe wrapper's `reg_req_t`/`reg_rsp_t` port, so safe-mode sequences run without CPU register pokes.

---
 rtl/safe_job_pkg.sv | 46 ++++
 rtl/safe_wrapper_ctrl_reg_pkg.sv | 22 ++
 rtl/safe_job_watchdog.sv | 30 +++
 rtl/safe_wrapper_job_launcher.sv | 181 ++++++++++++++++++
 tb/tb_safe_wrapper_job_launcher.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/safe_job_pkg.sv
// rtl/safe_job_pkg.sv - types, states and status codes for the safe wrapper job launcher
package safe_job_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MCORE,
    S_WR_DMR,
    S_WR_CFG,
    S_WR_INTEN,
    S_WR_START,
    S_WAIT_IRQ,
    S_RD_STAT,
    S_WR_INTCLR,
    S_DONE
  } launch_state_e;

  localparam logic [1:0] SJ_OK      = 2'b00;
  localparam logic [1:0] SJ_BUS_ERR = 2'b01;
  localparam logic [1:0] SJ_TIMEOUT = 2'b10;

  typedef struct packed {
    logic [2:0] master_core;
    logic [2:0] dmr_mask;
    logic [1:0] safe_config;
  } safe_job_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } sj_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } sj_reg_rsp_t;

  function automatic logic is_bus_state(launch_state_e s);
    return s inside {S_WR_MCORE, S_WR_DMR, S_WR_CFG, S_WR_INTEN,
                     S_WR_START, S_RD_STAT, S_WR_INTCLR};
  endfunction

endpackage

// File: rtl/safe_wrapper_ctrl_reg_pkg.sv
// rtl/safe_wrapper_ctrl_reg_pkg.sv - safe wrapper control register offsets and field positions
package safe_wrapper_ctrl_reg_pkg;

  parameter int BlockAw = 5;

  parameter logic [BlockAw-1:0] SAFE_WRAPPER_CTRL_MASTER_CORE_OFFSET        = 5'h00;
  parameter logic [BlockAw-1:0] SAFE_WRAPPER_CTRL_DMR_MASK_OFFSET           = 5'h04;
  parameter logic [BlockAw-1:0] SAFE_WRAPPER_CTRL_SAFE_CONFIGURATION_OFFSET = 5'h08;
  parameter logic [BlockAw-1:0] SAFE_WRAPPER_CTRL_INTERRUPT_OFFSET          = 5'h0c;
  parameter logic [BlockAw-1:0] SAFE_WRAPPER_CTRL_START_OFFSET              = 5'h10;
  parameter logic [BlockAw-1:0] SAFE_WRAPPER_CTRL_STATUS_OFFSET             = 5'h14;

  parameter int SAFE_WRAPPER_CTRL_MASTER_CORE_LSB        = 0;
  parameter int SAFE_WRAPPER_CTRL_DMR_MASK_LSB           = 0;
  parameter int SAFE_WRAPPER_CTRL_SAFE_CONFIGURATION_LSB = 0;
  parameter int SAFE_WRAPPER_CTRL_ENABLE_INTERRUPT_BIT   = 0;
  parameter int SAFE_WRAPPER_CTRL_STATUS_INTERRUPT_BIT   = 1;
  parameter int SAFE_WRAPPER_CTRL_START_BIT              = 0;
  parameter int SAFE_WRAPPER_CTRL_CORES_SLEEP_LSB        = 0;
  parameter int SAFE_WRAPPER_CTRL_CORES_DEBUG_MODE_LSB   = 3;

endpackage

// File: rtl/safe_job_watchdog.sv
// rtl/safe_job_watchdog.sv - loadable down-counter bounding the wait for the end-of-routine irq
// Present only when SAFE_JOB_WATCHDOG_EN is defined.
`ifdef SAFE_JOB_WATCHDOG_EN
module safe_job_watchdog #(
  parameter int unsigned W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (dec_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign expired_o = (r_cnt == '0);

endmodule
`endif

// File: rtl/safe_wrapper_job_launcher.sv
// rtl/safe_wrapper_job_launcher.sv - register-bus initiator that programs, starts and retires safe wrapper jobs
// Optional irq watchdog enabled by defining SAFE_JOB_WATCHDOG_EN.
module safe_wrapper_job_launcher
  import safe_job_pkg::*;
  import safe_wrapper_ctrl_reg_pkg::*;
#(
  parameter type         reg_req_t = sj_reg_req_t,
  parameter type         reg_rsp_t = sj_reg_rsp_t,
  parameter int unsigned NHARTS    = 3,
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  job_valid_i,
  output logic                  job_ready_o,
  input  logic [2:0]            job_master_core_i,
  input  logic [2:0]            job_safe_mode_i,
  input  logic [1:0]            job_safe_config_i,
  input  logic [TIMEOUT_W-1:0]  job_timeout_i,
  output reg_req_t              reg_req_o,
  input  reg_rsp_t              reg_rsp_i,
  input  logic                  irq_i,
  output logic                  done_valid_o,
  input  logic                  done_ready_i,
  output logic [1:0]            done_status_o,
  output logic [2*NHARTS-1:0]   done_hart_status_o,
  output logic                  busy_o
);

  launch_state_e       r_state, w_state_next, w_seq_next;
  safe_job_t           r_desc, w_job_in, w_desc;
  reg_req_t            r_req;
  logic                r_job_ready, r_irq_seen, r_timed_out;
  logic [1:0]          r_status;
  logic [2*NHARTS-1:0] r_hart;
  logic                w_accept, w_ack, w_err, w_irq_hit, w_expired;
  logic [31:0]         w_addr, w_wdata;
  logic                w_write;
  logic                w_unused_rdata;

  assign w_job_in  = '{master_core: job_master_core_i,
                       dmr_mask:    job_safe_mode_i,
                       safe_config: job_safe_config_i};
  // The first request is built in the accept cycle, before r_desc holds the job.
  assign w_desc    = (r_state == S_IDLE) ? w_job_in : r_desc;
  assign w_accept  = r_job_ready && job_valid_i;
  assign w_ack     = r_req.valid && reg_rsp_i.ready;
  assign w_err     = w_ack && reg_rsp_i.error;
  assign w_irq_hit = r_irq_seen || irq_i;
  assign w_unused_rdata = ^reg_rsp_i.rdata;

`ifdef SAFE_JOB_WATCHDOG_EN
  safe_job_watchdog #(
    .W(TIMEOUT_W)
  ) u_watchdog (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     ((r_state == S_WR_START) && w_ack),
    .load_val_i (job_timeout_i),
    .dec_i      (r_state == S_WAIT_IRQ),
    .expired_o  (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^job_timeout_i;
  assign w_expired        = 1'b0;
`endif

  always_comb begin
    w_seq_next   = S_IDLE;
    w_state_next = r_state;
    case (r_state)
      S_WR_MCORE:  w_seq_next = S_WR_DMR;
      S_WR_DMR:    w_seq_next = S_WR_CFG;
      S_WR_CFG:    w_seq_next = S_WR_INTEN;
      S_WR_INTEN:  w_seq_next = S_WR_START;
      S_WR_START:  w_seq_next = S_WAIT_IRQ;
      S_RD_STAT:   w_seq_next = S_WR_INTCLR;
      S_WR_INTCLR: w_seq_next = S_DONE;
      default:     w_seq_next = S_IDLE;
    endcase
    case (r_state)
      S_IDLE:     if (w_accept) w_state_next = S_WR_MCORE;
      S_WAIT_IRQ: begin
        if (w_irq_hit)      w_state_next = S_RD_STAT;
        else if (w_expired) w_state_next = S_WR_INTCLR;
      end
      S_DONE:     if (done_ready_i) w_state_next = S_IDLE;
      default: begin
        if (!is_bus_state(r_state)) w_state_next = S_IDLE;
        else if (w_ack)             w_state_next = reg_rsp_i.error ? S_DONE : w_seq_next;
      end
    endcase
  end

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_write = 1'b1;
    case (w_state_next)
      S_WR_MCORE: begin
        w_addr = 32'(SAFE_WRAPPER_CTRL_MASTER_CORE_OFFSET);
        w_wdata[SAFE_WRAPPER_CTRL_MASTER_CORE_LSB +: 3] = w_desc.master_core;
      end
      S_WR_DMR: begin
        w_addr = 32'(SAFE_WRAPPER_CTRL_DMR_MASK_OFFSET);
        w_wdata[SAFE_WRAPPER_CTRL_DMR_MASK_LSB +: 3] = w_desc.dmr_mask;
      end
      S_WR_CFG: begin
        w_addr = 32'(SAFE_WRAPPER_CTRL_SAFE_CONFIGURATION_OFFSET);
        w_wdata[SAFE_WRAPPER_CTRL_SAFE_CONFIGURATION_LSB +: 2] = w_desc.safe_config;
      end
      S_WR_INTEN: begin
        w_addr = 32'(SAFE_WRAPPER_CTRL_INTERRUPT_OFFSET);
        w_wdata[SAFE_WRAPPER_CTRL_ENABLE_INTERRUPT_BIT] = 1'b1;
      end
      S_WR_START: begin
        w_addr = 32'(SAFE_WRAPPER_CTRL_START_OFFSET);
        w_wdata[SAFE_WRAPPER_CTRL_START_BIT] = 1'b1;
      end
      S_RD_STAT: begin
        w_addr  = 32'(SAFE_WRAPPER_CTRL_STATUS_OFFSET);
        w_write = 1'b0;
      end
      S_WR_INTCLR: w_addr = 32'(SAFE_WRAPPER_CTRL_INTERRUPT_OFFSET);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_desc      <= '0;
      r_req       <= '0;
      r_job_ready <= 1'b0;
      r_irq_seen  <= 1'b0;
      r_timed_out <= 1'b0;
      r_status    <= SJ_OK;
      r_hart      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_job_ready <= (w_state_next == S_IDLE);

      r_req <= '0;
      if (is_bus_state(w_state_next)) begin
        r_req.valid <= 1'b1;
        r_req.addr  <= w_addr;
        r_req.write <= w_write;
        r_req.wdata <= w_wdata;
        r_req.wstrb <= 4'hF;
      end

      if (w_accept) begin
        r_desc      <= w_job_in;
        r_irq_seen  <= 1'b0;
        r_timed_out <= 1'b0;
      end else if (irq_i && (((r_state == S_WR_START) && w_ack) || (r_state == S_WAIT_IRQ))) begin
        r_irq_seen  <= 1'b1;
      end

      if ((r_state == S_WAIT_IRQ) && !w_irq_hit && w_expired) r_timed_out <= 1'b1;

      if ((r_state == S_RD_STAT) && w_ack && !reg_rsp_i.error) begin
        r_hart <= {reg_rsp_i.rdata[SAFE_WRAPPER_CTRL_CORES_DEBUG_MODE_LSB +: NHARTS],
                   reg_rsp_i.rdata[SAFE_WRAPPER_CTRL_CORES_SLEEP_LSB +: NHARTS]};
      end

      if ((r_state != S_DONE) && (w_state_next == S_DONE)) begin
        r_status <= w_err ? SJ_BUS_ERR : (r_timed_out ? SJ_TIMEOUT : SJ_OK);
      end
    end
  end

  assign reg_req_o          = r_req;
  assign job_ready_o        = r_job_ready;
  assign done_valid_o       = (r_state == S_DONE);
  assign done_status_o      = r_status;
  assign done_hart_status_o = r_hart;
  assign busy_o             = (r_state != S_IDLE);

endmodule

// File: tb/tb_safe_wrapper_job_launcher.sv
// tb/tb_safe_wrapper_job_launcher.sv - randomized self-checking bench for safe_wrapper_job_launcher
module tb_safe_wrapper_job_launcher;
  import safe_job_pkg::*;
  import safe_wrapper_ctrl_reg_pkg::*;

  localparam int NH = 3;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          job_valid, job_ready;
  logic [2:0]    job_mc, job_dm;
  logic [1:0]    job_cf;
  logic [TW-1:0] job_tmo;
  sj_reg_req_t   req;
  sj_reg_rsp_t   rsp;
  logic          irq;
  logic          done_valid, done_ready;
  logic [1:0]    done_status;
  logic [2*NH-1:0] done_hart;
  logic          busy;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  safe_wrapper_job_launcher #(.NHARTS(NH), .TIMEOUT_W(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .job_master_core_i(job_mc), .job_safe_mode_i(job_dm), .job_safe_config_i(job_cf),
    .job_timeout_i(job_tmo),
    .reg_req_o(req), .reg_rsp_i(rsp), .irq_i(irq),
    .done_valid_o(done_valid), .done_ready_i(done_ready),
    .done_status_o(done_status), .done_hart_status_o(done_hart), .busy_o(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register-file responder: programmable wait states, one error slot, irq scheduling.
  bit          bus_hold = 1'b1;
  int          waits = 0, err_idx = 99, irq_d = -1, irq_at = -100;
  int          acc_idx = 0, wcnt = 0, first_cyc = 0, stab_viol = 0;
  bit          pending = 1'b0;
  sj_reg_req_t snap;
  logic [31:0] stat_word = '0;
  logic [31:0] q_addr[$];
  logic        q_we[$];
  logic [31:0] q_wd[$];
  logic [3:0]  q_ws[$];
  int          q_first[$];
  int          q_done[$];
  logic [5:0]  last_hart = '0;

  initial begin
    rsp = '0;
    irq = 1'b0;
    forever begin
      @(negedge clk);
      rsp = '0;
      if (bus_hold || !req.valid) begin
        pending = 1'b0;
        wcnt    = 0;
      end else begin
        if (pending && (req !== snap)) stab_viol++;
        if (!pending) begin
          pending   = 1'b1;
          snap      = req;
          first_cyc = cyc;
        end
        if (wcnt < waits) begin
          wcnt++;
        end else begin
          rsp.ready = 1'b1;
          rsp.error = (acc_idx == err_idx);
          rsp.rdata = req.write ? $urandom : stat_word;
          q_addr.push_back(req.addr);
          q_we.push_back(req.write);
          q_wd.push_back(req.wdata);
          q_ws.push_back(req.wstrb);
          q_first.push_back(first_cyc);
          q_done.push_back(cyc);
          if ((req.addr == 32'(SAFE_WRAPPER_CTRL_START_OFFSET)) && !rsp.error && (irq_d >= 0))
            irq_at = cyc + irq_d;
          acc_idx++;
          pending = 1'b0;
          wcnt    = 0;
        end
      end
      irq = (cyc == irq_at);
    end
  end

  task automatic setup_bus(input int w, input int e, input int d);
    waits = w; err_idx = e; irq_d = d; irq_at = -100;
    acc_idx = 0; stab_viol = 0;
    q_addr.delete(); q_we.delete(); q_wd.delete(); q_ws.delete();
    q_first.delete(); q_done.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus_hold = 1'b1; job_valid = 1'b0; done_ready = 1'b0; irq_at = -100;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; bus_hold = 1'b0;
    last_hart = '0;
    @(negedge clk);
  endtask

  task automatic present_job(input logic [2:0] mc, input logic [2:0] dm, input logic [1:0] cf,
                             input int tmo, output int acc_cyc);
    @(negedge clk);
    job_mc = mc; job_dm = dm; job_cf = cf; job_tmo = TW'(tmo); job_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      if (job_ready) begin acc_cyc = cyc; break; end
      @(negedge clk);
    end
    check("accept", 64'(acc_cyc >= 0), 1);
    @(negedge clk);
    job_mc = ~mc; job_dm = ~dm; job_cf = ~cf;
  endtask

  task automatic run_job(input logic [2:0] mc, input logic [2:0] dm, input logic [1:0] cf,
                         input int w, input int e, input int d, input int tmo, input bit exp_to);
    logic [31:0] ea[$];
    logic        ew[$];
    logic [31:0] ed[$];
    int          nexp, acc_cyc, done_cyc, n;
    logic [1:0]  est;
    logic [5:0]  eh;
    ea = {32'(SAFE_WRAPPER_CTRL_MASTER_CORE_OFFSET), 32'(SAFE_WRAPPER_CTRL_DMR_MASK_OFFSET),
          32'(SAFE_WRAPPER_CTRL_SAFE_CONFIGURATION_OFFSET), 32'(SAFE_WRAPPER_CTRL_INTERRUPT_OFFSET),
          32'(SAFE_WRAPPER_CTRL_START_OFFSET)};
    ew = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ed = {32'(mc), 32'(dm), 32'(cf), 32'd1, 32'd1};
    if (!exp_to) begin
      ea.push_back(32'(SAFE_WRAPPER_CTRL_STATUS_OFFSET)); ew.push_back(1'b0); ed.push_back(32'd0);
    end
    ea.push_back(32'(SAFE_WRAPPER_CTRL_INTERRUPT_OFFSET)); ew.push_back(1'b1); ed.push_back(32'd0);
    nexp = (e < ea.size()) ? e + 1 : ea.size();
    est  = (e < ea.size()) ? 2'd1 : (exp_to ? 2'd2 : 2'd0);
    stat_word = $urandom;
    eh = (!exp_to && e > 5) ? stat_word[5:0] : last_hart;
    setup_bus(w, e, exp_to ? -1 : d);

    present_job(mc, dm, cf, tmo, acc_cyc);
    done_cyc = -1;
    for (int i = 0; i < 4000; i++) begin
      if (done_valid) begin done_cyc = cyc; break; end
      @(negedge clk);
    end
    job_valid = 1'b0;
    check("done_seen", 64'(done_cyc >= 0), 1);
    if (done_cyc < 0) begin
      do_reset();
      return;
    end

    check("status", done_status, est);
    check("hart", done_hart, eh);
    check("n_acc", q_addr.size(), nexp);
    check("stable", stab_viol, 0);
    n = (q_addr.size() < nexp) ? q_addr.size() : nexp;
    for (int i = 0; i < n; i++) begin
      check($sformatf("addr%0d", i), q_addr[i], ea[i]);
      check($sformatf("we%0d", i), q_we[i], ew[i]);
      check($sformatf("wdata%0d", i), q_wd[i], ed[i]);
      check($sformatf("wstrb%0d", i), q_ws[i], 4'hF);
    end
    if (q_first.size() > 0) begin
      check("accept_lat", q_first[0] - acc_cyc, 1);
      check("done_lat", done_cyc - q_done[q_done.size()-1], 1);
    end
    if (e > 5 && q_first.size() > 5) begin
      if (exp_to) check("wd_lat", q_first[5] - q_done[4], tmo + 2);
      else        check("irq_lat", q_first[5] - q_done[4], ((d < 1) ? 1 : d) + 1);
    end

    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("hold_valid", done_valid, 1);
    check("hold_status", done_status, est);
    check("hold_hart", done_hart, eh);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    check("release_valid", done_valid, 0);
    check("release_busy", busy, 0);
    check("release_ready", job_ready, 1);
    last_hart = eh;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int acc_cyc;
    bit saw;
    rst_n = 1'b0; job_valid = 1'b0; done_ready = 1'b0;
    job_mc = '0; job_dm = '0; job_cf = '0; job_tmo = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", req.valid, 0);
    check("rst_addr", req.addr, 0);
    check("rst_wdata", req.wdata, 0);
    check("rst_done", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_status", done_status, 0);
    check("rst_hart", done_hart, 0);
    check("rst_ready", job_ready, 0);
    rst_n = 1'b1; bus_hold = 1'b0;
    @(negedge clk);
    check("ready_after_rst", job_ready, 1);

    run_job(3'b001, 3'b011, 2'b01, 0, 99, 20, 5000, 1'b0);
    run_job(3'b001, 3'b011, 2'b01, 3, 99, 20, 5000, 1'b0);
    run_job(3'b100, 3'b111, 2'b10, 0, 99, 0, 5000, 1'b0);
    run_job(3'b010, 3'b101, 2'b11, 0, 2, 5, 5000, 1'b0);
    run_job(3'b110, 3'b001, 2'b00, 2, 5, 3, 5000, 1'b0);

`ifdef SAFE_JOB_WATCHDOG_EN
    run_job(3'b011, 3'b010, 2'b01, 0, 99, 0, 10, 1'b1);
    run_job(3'b011, 3'b010, 2'b01, 1, 99, 0, 0, 1'b1);
`else
    setup_bus(0, 99, -1);
    present_job(3'b011, 3'b010, 2'b01, 10, acc_cyc);
    job_valid = 1'b0;
    repeat (1000) @(negedge clk);
    check("hang_busy", busy, 1);
    check("hang_done", done_valid, 0);
    check("hang_n_acc", q_addr.size(), 5);
    check("hang_valid", req.valid, 0);
    do_reset();
`endif

    // Reset while the DMR write is outstanding.
    setup_bus(3, 99, 20);
    present_job(3'b101, 3'b110, 2'b10, 5000, acc_cyc);
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (q_addr.size() == 1 && req.valid && req.addr == 32'(SAFE_WRAPPER_CTRL_DMR_MASK_OFFSET)) begin
        saw = 1'b1; break;
      end
      @(negedge clk);
    end
    check("reached_dmr", saw, 1);
    rst_n = 1'b0; bus_hold = 1'b1; job_valid = 1'b0; irq_at = -100;
    @(posedge clk); #1;
    check("midrst_valid", req.valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done_valid, 0);
    @(negedge clk);
    rst_n = 1'b1; bus_hold = 1'b0; last_hart = '0;
    saw = 1'b0;
    repeat (10) begin @(negedge clk); saw |= done_valid; end
    check("midrst_no_done", saw, 0);
    run_job(3'b001, 3'b011, 2'b01, 1, 99, 4, 5000, 1'b0);

    for (int j = 0; j < 12; j++) begin
      int e;
      e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 99;
      run_job(3'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 3), e,
              $urandom_range(0, 25), 5000, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
